// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Shares the register file's single write port between the pipeline
// writeback stage and a long-latency (multiply/divide) unit.
//
// Pipeline writeback always wins the port and is never back-pressured.
// Long-latency results wait in a small FIFO and drain on cycles where
// the pipeline does not write. If buffered results are refused the port
// for STARVE_LIMIT consecutive cycles, a one-cycle pipe_stall is requested
// so the head can be written.
//
// Ports:
//   Clk, Rst_n                  clock (rising edge), async active-low reset
//   wb_valid/wb_reg/wb_data     pipeline writeback request
//   lu_valid/lu_reg/lu_data     long-latency result, accepted when lu_ready
//   lu_ready                    FIFO has a free slot
//   ReadRegister1/2             source registers being decoded
//   hazard1/2                   source has a buffered, unwritten result
//   pipe_stall                  pipeline must present wb_valid=0 this cycle
//   RegWrite/WriteRegister/WriteData   register file write port
//   protocol_err                sticky: wb_valid seen while pipe_stall high
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        pipe_stall,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifoReg  [DEPTH];
    logic [31:0]      fifoData [DEPTH];
    logic [DEPTH-1:0] slotValid;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             doPush;
    logic             doPop;
    logic [4:0]       headReg;
    logic [31:0]      headData;
    logic [CNT_W-1:0] starveCnt;
    logic [CNT_W-1:0] starveNext;

    // Each slot carries its own valid bit, so empty/full fall straight out
    // of the slot the read/write pointer is looking at: the read slot is
    // unoccupied only when empty, the write slot occupied only when full.
    assign fifoEmpty = !slotValid[rdPtr];
    assign fifoFull  = slotValid[wrPtr];
    assign lu_ready  = !fifoFull;
    assign doPush    = lu_valid && !fifoFull;
    assign headReg   = fifoReg[rdPtr];
    assign headData  = fifoData[rdPtr];

    // Write-port grant. Writeback always wins; the FIFO head only gets the
    // port on idle cycles. Register 0 still consumes the grant but never
    // asserts RegWrite. When writeback targets the same register as the
    // head, the head is stale (the writeback is younger because issue
    // stalls on hazards), so it is popped and dropped. Outputs are forced
    // low while reset is asserted so the register file sees no write.
    always_comb begin
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        doPop         = 1'b0;
        if (!Rst_n) begin
            doPop = 1'b0;
        end else if (wb_valid) begin
            RegWrite      = (wb_reg != 5'd0);
            WriteRegister = wb_reg;
            WriteData     = wb_data;
            doPop         = !fifoEmpty && (headReg == wb_reg) && (wb_reg != 5'd0);
        end else if (!fifoEmpty) begin
            RegWrite      = (headReg != 5'd0);
            WriteRegister = headReg;
            WriteData     = headData;
            doPop         = 1'b1;
        end
    end

    // FIFO control. A push never lands on the slot being popped because a
    // push needs the write slot free while a pop needs the read slot full.
    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            slotValid <= '0;
        end else begin
            if (doPop) begin
                slotValid[rdPtr] <= 1'b0;
                rdPtr            <= rdPtr + PTR_W'(1);
            end
            if (doPush) begin
                slotValid[wrPtr] <= 1'b1;
                wrPtr            <= wrPtr + PTR_W'(1);
            end
        end
    end

    // FIFO payload storage. Contents are only meaningful under slotValid,
    // so the array itself needs no reset.
    always_ff @(posedge Clk) begin
        if (doPush) begin
            fifoReg[wrPtr]  <= lu_reg;
            fifoData[wrPtr] <= lu_data;
        end
    end

    // Read-hazard detection: a source register is hazardous while any
    // occupied slot targets it, including the slot being popped this cycle.
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotValid[i] && (fifoReg[i] == ReadRegister1) && (ReadRegister1 != 5'd0))
                hazard1 = 1'b1;
            if (slotValid[i] && (fifoReg[i] == ReadRegister2) && (ReadRegister2 != 5'd0))
                hazard2 = 1'b1;
        end
    end

    // Starvation counting: only cycles where buffered data is waiting and
    // writeback holds the port count. Any pop, an empty FIFO, or the stall
    // cycle itself restarts the count.
    always_comb begin
        starveNext = '0;
        if (!pipe_stall && !doPop && !fifoEmpty && wb_valid) begin
            starveNext = (starveCnt == CNT_W'(STARVE_LIMIT)) ? starveCnt
                                                             : starveCnt + CNT_W'(1);
        end
    end

    // Stall request is registered from the counter reaching the limit, so
    // it is a clean one-cycle pulse; protocol_err latches any writeback
    // that ignores it and holds until reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            starveCnt    <= '0;
            pipe_stall   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            starveCnt  <= starveNext;
            pipe_stall <= (starveNext == CNT_W'(STARVE_LIMIT));
            if (wb_valid && pipe_stall)
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter. Directed scenarios compare
// against fixed expected values; the random scenario compares every output
// against a queue-based reference model of the arbitration rules. Inputs are
// driven 1 time unit after the rising edge, outputs checked 2 units later.
module tb_regfile_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 8;

    logic        Clk;
    logic        Rst_n;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        hazard1;
    logic        hazard2;
    logic        pipe_stall;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        protocol_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t q[$];
    int     mStarve;
    bit     mStall;
    bit     mErr;

    logic        eRegWrite;
    logic [4:0]  eWR;
    logic [31:0] eWD;
    logic        eReady;
    logic        eHaz1;
    logic        eHaz2;
    logic        eStall;
    logic        eErr;
    bit          ePop;

    regfile_wb_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .wb_valid(wb_valid),
        .wb_reg(wb_reg),
        .wb_data(wb_data),
        .lu_valid(lu_valid),
        .lu_reg(lu_reg),
        .lu_data(lu_data),
        .lu_ready(lu_ready),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .hazard1(hazard1),
        .hazard2(hazard2),
        .pipe_stall(pipe_stall),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .protocol_err(protocol_err)
    );

    // Free-running clock, period 10.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard time limit so a wedged run still reports and terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelReset();
        q.delete();
        mStarve = 0;
        mStall  = 1'b0;
        mErr    = 1'b0;
    endfunction

    // Expected outputs for the current inputs and model contents.
    function automatic void modelExpect();
        eReady    = (q.size() < DEPTH);
        eStall    = mStall;
        eErr      = mErr;
        ePop      = 1'b0;
        eRegWrite = 1'b0;
        eWR       = '0;
        eWD       = '0;
        if (wb_valid) begin
            eRegWrite = (wb_reg != 5'd0);
            eWR       = wb_reg;
            eWD       = wb_data;
            ePop      = (q.size() > 0) && (q[0].r == wb_reg) && (wb_reg != 5'd0);
        end else if (q.size() > 0) begin
            eRegWrite = (q[0].r != 5'd0);
            eWR       = q[0].r;
            eWD       = q[0].d;
            ePop      = 1'b1;
        end
        eHaz1 = 1'b0;
        eHaz2 = 1'b0;
        foreach (q[i]) begin
            if (ReadRegister1 != 5'd0 && q[i].r == ReadRegister1) eHaz1 = 1'b1;
            if (ReadRegister2 != 5'd0 && q[i].r == ReadRegister2) eHaz2 = 1'b1;
        end
    endfunction

    // Drive one cycle's inputs and compute what the model expects.
    task automatic applyStimulus(input logic wbV, input logic [4:0] wbR, input logic [31:0] wbD,
                                 input logic luV, input logic [4:0] luR, input logic [31:0] luD,
                                 input logic [4:0] rr1, input logic [4:0] rr2);
        wb_valid      = wbV;
        wb_reg        = wbR;
        wb_data       = wbD;
        lu_valid      = luV;
        lu_reg        = luR;
        lu_data       = luD;
        ReadRegister1 = rr1;
        ReadRegister2 = rr2;
        #2;
        modelExpect();
    endtask

    // Advance one rising edge and update the model with that cycle's effects.
    task automatic clockEdge();
        bit nonEmpty;
        bit pushOk;
        bit popNow;
        bit wbNow;
        nonEmpty = (q.size() > 0);
        pushOk   = lu_valid && (q.size() < DEPTH);
        popNow   = ePop;
        wbNow    = wb_valid;
        @(posedge Clk);
        if (!Rst_n) begin
            modelReset();
        end else begin
            if (wbNow && mStall) mErr = 1'b1;
            if (mStall || popNow || !nonEmpty) mStarve = 0;
            else if (wbNow) mStarve = (mStarve < STARVE_LIMIT) ? mStarve + 1 : mStarve;
            mStall = (mStarve == STARVE_LIMIT);
            if (popNow) void'(q.pop_front());
            if (pushOk) q.push_back('{lu_reg, lu_data});
        end
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        modelReset();
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd6, 32'h1, 5'd6, 5'd5);
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_regwrite got=%0b exp=0", RegWrite); end
        checks++; if (WriteRegister !== 5'd0) begin failures++; $display("[TB] FAIL reset_wreg got=%0d exp=0", WriteRegister); end
        checks++; if (WriteData !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata got=%h exp=0", WriteData); end
        checks++; if (lu_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_lu_ready got=%0b exp=1", lu_ready); end
        checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_hazard got=%0b%0b exp=00", hazard1, hazard2); end
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b exp=0", pipe_stall); end
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_perr got=%0b exp=0", protocol_err); end
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        clockEdge();
        Rst_n = 1'b1;
    endtask

    task automatic test_wb_write();
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (RegWrite !== 1'b1) begin failures++; $display("[TB] FAIL wb_regwrite got=%0b exp=1", RegWrite); end
        checks++; if (WriteRegister !== 5'd5) begin failures++; $display("[TB] FAIL wb_wreg got=%0d exp=5", WriteRegister); end
        checks++; if (WriteData !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL wb_wdata got=%h exp=deadbeef", WriteData); end
        checks++; if (lu_ready !== 1'b1) begin failures++; $display("[TB] FAIL wb_lu_ready got=%0b exp=1", lu_ready); end
        clockEdge();
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL wb_r0_regwrite got=%0b exp=0", RegWrite); end
        clockEdge();
    endtask

    task automatic test_drain_order();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h11, 5'd9, 5'd0);
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL drain_c0_regwrite got=%0b exp=0", RegWrite); end
        checks++; if (hazard1 !== 1'b0) begin failures++; $display("[TB] FAIL drain_c0_haz got=%0b exp=0", hazard1); end
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22, 5'd9, 5'd8);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd8 || WriteData !== 32'h11) begin failures++; $display("[TB] FAIL drain_c1_write got=%0b/%0d/%h exp=1/8/11", RegWrite, WriteRegister, WriteData); end
        checks++; if (hazard2 !== 1'b1) begin failures++; $display("[TB] FAIL drain_c1_haz8 got=%0b exp=1", hazard2); end
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd8);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 32'h22) begin failures++; $display("[TB] FAIL drain_c2_write got=%0b/%0d/%h exp=1/9/22", RegWrite, WriteRegister, WriteData); end
        checks++; if (hazard1 !== 1'b1) begin failures++; $display("[TB] FAIL drain_c2_haz9 got=%0b exp=1", hazard1); end
        checks++; if (hazard2 !== 1'b0) begin failures++; $display("[TB] FAIL drain_c2_haz8 got=%0b exp=0", hazard2); end
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        checks++; if (hazard1 !== 1'b0 || RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL drain_c3_idle got=haz%0b/rw%0b exp=0/0", hazard1, RegWrite); end
        clockEdge();
    endtask

    task automatic test_starvation();
        int denied;
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd20, 32'hAAAA_0001, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd21, 32'hAAAA_0002, 5'd0, 5'd0);
        clockEdge();
        denied = 1;
        while (pipe_stall !== 1'b1 && denied < 20) begin
            applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'hBBBB, 5'd0, 5'd0);
            if (denied == 1) begin
                checks++; if (lu_ready !== 1'b0) begin failures++; $display("[TB] FAIL starve_full_ready got=%0b exp=0", lu_ready); end
            end
            clockEdge();
            denied++;
        end
        checks++; if (denied != STARVE_LIMIT) begin failures++; $display("[TB] FAIL starve_denied_cycles got=%0d exp=%0d", denied, STARVE_LIMIT); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd20 || WriteData !== 32'hAAAA_0001) begin failures++; $display("[TB] FAIL starve_head_write got=%0b/%0d/%h exp=1/20/aaaa0001", RegWrite, WriteRegister, WriteData); end
        clockEdge();
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            checks++; if (pipe_stall !== 1'b0) begin failures++; $display("[TB] FAIL starve_restart k=%0d got=%0b exp=0", k, pipe_stall); end
            applyStimulus(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            clockEdge();
        end
        checks++; if (pipe_stall !== 1'b1) begin failures++; $display("[TB] FAIL starve_second_stall got=%0b exp=1", pipe_stall); end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (WriteRegister !== 5'd21 || WriteData !== 32'hAAAA_0002) begin failures++; $display("[TB] FAIL starve_second_head got=%0d/%h exp=21/aaaa0002", WriteRegister, WriteData); end
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("[TB] FAIL starve_stall_one_cycle got=%0b exp=0", pipe_stall); end
        clockEdge();
    endtask

    task automatic test_collision();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h0000_1234, 5'd12, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd12, 32'h0000_CAFE, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd12 || WriteData !== 32'h0000_CAFE) begin failures++; $display("[TB] FAIL collide_wb_write got=%0b/%0d/%h exp=1/12/cafe", RegWrite, WriteRegister, WriteData); end
        checks++; if (hazard1 !== 1'b1) begin failures++; $display("[TB] FAIL collide_haz_during got=%0b exp=1", hazard1); end
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        checks++; if (hazard1 !== 1'b0) begin failures++; $display("[TB] FAIL collide_haz_after got=%0b exp=0", hazard1); end
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL collide_discarded got=%0b exp=0", RegWrite); end
        clockEdge();
    endtask

    task automatic test_protocol_err();
        int waited;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h0000_0E0E, 5'd0, 5'd0);
        clockEdge();
        waited = 0;
        while (pipe_stall !== 1'b1 && waited < 20) begin
            applyStimulus(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            clockEdge();
            waited++;
        end
        checks++; if (pipe_stall !== 1'b1) begin failures++; $display("[TB] FAIL perr_stall_timeout got=%0b exp=1", pipe_stall); end
        applyStimulus(1'b1, 5'd7, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'h0BAD_F00D) begin failures++; $display("[TB] FAIL perr_wb_wins got=%0b/%0d/%h exp=1/7/0badf00d", RegWrite, WriteRegister, WriteData); end
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("[TB] FAIL perr_early got=%0b exp=0", protocol_err); end
        clockEdge();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            checks++; if (protocol_err !== 1'b1) begin failures++; $display("[TB] FAIL perr_sticky k=%0d got=%0b exp=1", k, protocol_err); end
            clockEdge();
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd16, 32'h1616, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd17, 32'h1717, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd17, 5'd16);
        checks++; if (lu_ready !== 1'b0 || hazard1 !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre got=rdy%0b/haz%0b exp=0/1", lu_ready, hazard1); end
        Rst_n = 1'b0;
        #1;
        checks++; if (lu_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ready got=%0b exp=1", lu_ready); end
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_regwrite got=%0b exp=0", RegWrite); end
        checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_hazard got=%0b%0b exp=00", hazard1, hazard2); end
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_perr got=%0b exp=0", protocol_err); end
        clockEdge();
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd17, 5'd16);
            checks++; if (RegWrite !== 1'b0 || hazard1 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_after k=%0d got=rw%0b/haz%0b exp=0/0", k, RegWrite, hazard1); end
            clockEdge();
        end
    endtask

    task automatic test_random();
        logic        wbV;
        logic        luV;
        logic [4:0]  wbR;
        logic [4:0]  luR;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] wbD;
        logic [31:0] luD;
        for (int c = 0; c < 400; c++) begin
            wbV = mStall ? 1'b0 : ($urandom_range(0, 9) < 7);
            luV = ($urandom_range(0, 9) < 5);
            wbR = 5'($urandom_range(0, 7));
            luR = 5'($urandom_range(0, 7));
            rr1 = 5'($urandom_range(0, 7));
            rr2 = 5'($urandom_range(0, 7));
            wbD = $urandom();
            luD = $urandom();
            applyStimulus(wbV, wbR, wbD, luV, luR, luD, rr1, rr2);
            checks++; if (RegWrite !== eRegWrite) begin failures++; $display("[TB] FAIL rnd_regwrite c=%0d got=%0b exp=%0b", c, RegWrite, eRegWrite); end
            checks++; if (WriteRegister !== eWR) begin failures++; $display("[TB] FAIL rnd_wreg c=%0d got=%0d exp=%0d", c, WriteRegister, eWR); end
            checks++; if (WriteData !== eWD) begin failures++; $display("[TB] FAIL rnd_wdata c=%0d got=%h exp=%h", c, WriteData, eWD); end
            checks++; if (lu_ready !== eReady) begin failures++; $display("[TB] FAIL rnd_lu_ready c=%0d got=%0b exp=%0b", c, lu_ready, eReady); end
            checks++; if (hazard1 !== eHaz1) begin failures++; $display("[TB] FAIL rnd_hazard1 c=%0d got=%0b exp=%0b", c, hazard1, eHaz1); end
            checks++; if (hazard2 !== eHaz2) begin failures++; $display("[TB] FAIL rnd_hazard2 c=%0d got=%0b exp=%0b", c, hazard2, eHaz2); end
            checks++; if (pipe_stall !== eStall) begin failures++; $display("[TB] FAIL rnd_stall c=%0d got=%0b exp=%0b", c, pipe_stall, eStall); end
            checks++; if (protocol_err !== eErr) begin failures++; $display("[TB] FAIL rnd_perr c=%0d got=%0b exp=%0b", c, protocol_err, eErr); end
            clockEdge();
        end
    endtask

    // Scenario sequence; ends with the single summary line.
    initial begin
        Rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        test_reset();
        test_wb_write();
        test_drain_order();
        test_starvation();
        test_collision();
        test_protocol_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite/WriteRegister/WriteData) between the pipeline writeback stage and a long-latency unit (multiply/divide).
- Pipeline writeback always has priority and is never back-pressured. Long-latency results are buffered in a small FIFO and drained on idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall so buffered results make progress.
- Read-hazard flags tell issue logic when a source register still has a buffered, unwritten result.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8, consecutive denied cycles with FIFO non-empty before pipe_stall is requested.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- lu_valid  in  1  long-latency result valid.
- lu_reg  in  5  long-latency destination register.
- lu_data  in  32  long-latency result data.
- lu_ready  out  1  FIFO can accept; transfer when lu_valid && lu_ready.
- ReadRegister1, ReadRegister2  in  5 each  source registers being decoded.
- hazard1, hazard2  out  1 each  matching source has a pending buffered write.
- pipe_stall  out  1  registered request: pipeline must present wb_valid=0 this cycle.
- RegWrite  out  1  to register file.
- WriteRegister  out  5  to register file.
- WriteData  out  32  to register file.
- protocol_err  out  1  sticky; wb_valid seen while pipe_stall high.

Behaviour:
- Reset (async, Rst_n low):
  - FIFO empty; starve counter 0.
  - pipe_stall=0, protocol_err=0, lu_ready=1.
  - hazard1/2=0; RegWrite=0, WriteRegister=0, WriteData=0.
- Write-port outputs are combinational from the current grant, so the register file writes on the same edge.
- Grant, evaluated each cycle:
  - wb_valid=1: grant WB. RegWrite=1, WriteRegister=wb_reg, WriteData=wb_data.
  - else FIFO non-empty: grant FIFO head, pop it. RegWrite=1, outputs from head.
  - else: RegWrite=0, WriteRegister=0, WriteData=0.
- Register 0:
  - WB with wb_reg=0 drives RegWrite=0 but still occupies the grant.
  - FIFO head with reg 0 is popped with RegWrite=0.
- Same-register collision: if WB is granted and FIFO head reg == wb_reg (non-zero), the head is popped and discarded. Issue logic stalls on hazard, so such a WB is always younger.
- FIFO accept:
  - lu_ready = !full, from registered occupancy.
  - No accept when full, even if a pop occurs that cycle.
  - Accept and pop in the same cycle leave occupancy unchanged.
  - Earliest write of an accepted entry is the cycle after acceptance.
  - Ordering is FIFO; pointers wrap modulo DEPTH.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and WB is granted.
  - Counter clears on any FIFO pop or when the FIFO is empty; saturates at STARVE_LIMIT.
  - When the counter reaches STARVE_LIMIT, pipe_stall=1 on the next cycle, for exactly one cycle; the counter then clears.
- Stall violation: if wb_valid=1 while pipe_stall=1, WB still wins and protocol_err sets, held until reset.
- Hazards:
  - hazardN=1 iff ReadRegisterN != 0 and equals the reg field of any valid FIFO entry.
  - Purely combinational on current FIFO contents.
  - The entry being popped this cycle still counts.
- Reset mid-operation: buffered entries are discarded with no write; all outputs return to reset values asynchronously.

Test Plan:
- Idle FIFO; wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF -> same cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; lu_ready=1.
- lu pushes (reg 8, 0x11) then (reg 9, 0x22) with wb_valid=0 -> writes reg 8 then reg 9 on the next two cycles; hazard1=1 for ReadRegister1=9 until reg 9 is written.
- FIFO full (DEPTH=2) with wb_valid held 1 -> lu_ready=0; after 8 denied cycles pipe_stall=1 for one cycle, FIFO head written that cycle, counter restarts.
- FIFO head reg 12 pending; wb_valid=1, wb_reg=12 -> WB data written, head discarded, hazard for 12 clears next cycle.
- wb_valid=1 during pipe_stall=1 -> WB written, protocol_err=1 and stays 1 until Rst_n low.
- FIFO holding 2 entries, Rst_n pulsed low mid-cycle -> lu_ready=1, RegWrite=0, hazards 0 immediately; no buffered write occurs after release.
